uriscv_irq_ctrl: RTL

URISCV_IRQ_CTRL -- requirements
Module: uriscv_irq_ctrl

---
 rtl/uriscv_irq_ctrl_pkg.sv | 26 ++
 rtl/uriscv_irq_sync.sv | 36 +++
 rtl/uriscv_irq_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uriscv_irq_ctrl_pkg.sv
// uriscv_defs: shared definitions for the interrupt controller slice.
//   - ID_W       : width of a source ID (0 = none, 1..31 = source index+1)
//   - REG_*      : byte offsets of the register map
//   - irq_state_e: controller FSM states
//   - reg_hit()  : word-address compare that ignores byte-lane bits
package uriscv_defs;

  localparam int ID_W = 5;

  localparam logic [7:0] REG_PENDING  = 8'h00;
  localparam logic [7:0] REG_ENABLE   = 8'h04;
  localparam logic [7:0] REG_EDGE     = 8'h08;
  localparam logic [7:0] REG_CLAIM    = 8'h0C;
  localparam logic [7:0] REG_COMPLETE = 8'h10;
  localparam logic [7:0] REG_BASE     = 8'h14;

  typedef enum logic {
    ST_IDLE       = 1'b0,
    ST_IN_SERVICE = 1'b1
  } irq_state_e;

  function automatic logic reg_hit(input logic [5:0] word_addr, input logic [7:0] offset);
    return word_addr == offset[7:2];
  endfunction

endpackage

// File: rtl/uriscv_irq_sync.sv
// uriscv_irq_sync: per-bit 2-flop synchronizer with rising-edge detect.
//   clk_i   in   clock
//   rst_i   in   asynchronous reset, active-low
//   async_i in   WIDTH raw asynchronous inputs
//   sync_o  out  WIDTH synchronized levels
//   rise_o  out  WIDTH one-cycle pulses on a synchronized 0->1 transition
module uriscv_irq_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/uriscv_irq_ctrl.sv
// uriscv_irq_ctrl: fixed-priority external interrupt controller with a
// claim/complete handshake towards the CSR unit.
//   clk_i        in   clock
//   rst_i        in   asynchronous reset, active-low
//   irq_i        in   NUM_IRQ raw interrupt sources
//   req_i/we_i   in   register access request / write enable
//   addr_i       in   byte address (bits [1:0] ignored)
//   wdata_i      in   write data
//   rdata_o      out  read data, valid with ack_o, otherwise 0
//   ack_o        out  access complete, one cycle after req_i
//   intr_o       out  interrupt request to the CSR unit
//   isr_vector_o out  handler address, BASE + 4*source index
module uriscv_irq_ctrl
  import uriscv_defs::*;
#(
  parameter int          NUM_IRQ     = 8,
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0100
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [7:0]         addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic               ack_o,
  output logic               intr_o,
  output logic [31:0]        isr_vector_o
);

  logic [NUM_IRQ-1:0] sync_lvl, sync_rise;
  logic [NUM_IRQ-1:0] enable_q, edge_q, edge_pend_q, edge_pend_d;
  logic [NUM_IRQ-1:0] pending, active, win_onehot;
  logic [31:0]        base_q, rdata_q, rdata_d;
  logic               ack_q;
  logic [ID_W-1:0]    in_service_id_q, in_service_id_d;
  logic [ID_W-1:0]    win_idx, win_id, vec_idx;
  logic               has_winner;
  irq_state_e         state_q, state_d;

  logic [5:0] word_addr;
  logic       rd_req, wr_req, claim_fire, complete_fire, edge_wr;
  logic       unused_ok;

  assign word_addr = addr_i[7:2];
  assign unused_ok = ^addr_i[1:0];
  assign rd_req    = req_i & ~we_i;
  assign wr_req    = req_i & we_i;

  uriscv_irq_sync #(.WIDTH(NUM_IRQ)) u_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (irq_i),
    .sync_o  (sync_lvl),
    .rise_o  (sync_rise)
  );

  // Level sources mirror the synchronized input; edge sources use the sticky bit.
  assign pending = (edge_q & edge_pend_q) | (~edge_q & sync_lvl);
  assign active  = pending & enable_q;

  // Lowest index wins: scan from the top so the last hit is the lowest.
  always_comb begin
    has_winner = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) begin
        has_winner    = 1'b1;
        win_idx       = ID_W'(i);
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
      end
    end
  end

  assign win_id        = win_idx + ID_W'(1);
  assign claim_fire    = rd_req & reg_hit(word_addr, REG_CLAIM) & (state_q == ST_IDLE) & has_winner;
  assign complete_fire = wr_req & reg_hit(word_addr, REG_COMPLETE) & (state_q == ST_IN_SERVICE)
                         & (wdata_i[ID_W-1:0] == in_service_id_q);
  assign edge_wr       = wr_req & reg_hit(word_addr, REG_EDGE);

  // A new edge wins over a claim in the same cycle; flipping the mode drops the bit.
  always_comb begin
    edge_pend_d = edge_pend_q;
    if (claim_fire) edge_pend_d = edge_pend_d & ~win_onehot;
    edge_pend_d = edge_pend_d | (sync_rise & edge_q);
    if (edge_wr) edge_pend_d = edge_pend_d & ~(edge_q ^ wdata_i[NUM_IRQ-1:0]);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      enable_q    <= '0;
      edge_q      <= '0;
      edge_pend_q <= '0;
      base_q      <= VECTOR_BASE;
    end else begin
      edge_pend_q <= edge_pend_d;
      if (wr_req && reg_hit(word_addr, REG_ENABLE)) enable_q <= wdata_i[NUM_IRQ-1:0];
      if (edge_wr) edge_q <= wdata_i[NUM_IRQ-1:0];
      if (wr_req && reg_hit(word_addr, REG_BASE)) base_q <= wdata_i;
    end
  end

  // Read data is captured with the request and presented alongside ack.
  always_comb begin
    rdata_d = '0;
    if (rd_req) begin
      if (reg_hit(word_addr, REG_PENDING))     rdata_d = 32'(pending);
      else if (reg_hit(word_addr, REG_ENABLE)) rdata_d = 32'(enable_q);
      else if (reg_hit(word_addr, REG_EDGE))   rdata_d = 32'(edge_q);
      else if (reg_hit(word_addr, REG_CLAIM))  rdata_d = claim_fire ? 32'(win_id) : 32'd0;
      else if (reg_hit(word_addr, REG_BASE))   rdata_d = base_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= req_i;
      rdata_q <= rdata_d;
    end
  end

  assign ack_o   = ack_q;
  assign rdata_o = rdata_q;

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q         <= ST_IDLE;
      in_service_id_q <= '0;
    end else begin
      state_q         <= state_d;
      in_service_id_q <= in_service_id_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d         = state_q;
    in_service_id_d = in_service_id_q;
    case (state_q)
      ST_IDLE: begin
        if (claim_fire) begin
          state_d         = ST_IN_SERVICE;
          in_service_id_d = win_id;
        end
      end
      ST_IN_SERVICE: begin
        if (complete_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; with no winner win_idx is 0, so the vector falls back to BASE.
  always_comb begin
    intr_o  = 1'b0;
    vec_idx = win_idx;
    if (state_q == ST_IDLE) begin
      intr_o = has_winner;
    end else begin
      vec_idx = in_service_id_q - ID_W'(1);
    end
    isr_vector_o = base_q + {{(32-ID_W-2){1'b0}}, vec_idx, 2'b00};
  end

endmodule
